fir_sym_pipe: RTL and testbench
===============================

Name: fir_sym_pipe

Overview:
- Parametrised, pipelined, symmetric (linear-phase) FIR filter; successor to the fixed 9-tap, 16-bit filter used in the approximate-adder study.
- Generalises tap count, data and coefficient widths, and the adder type (exact or approximate cell).
- Adds sample-valid qualification, runtime-writable coefficients, round/shift/saturate output and a flush.
- Sits between a sample source and the MRE metric capture logic.

Parameters:
- NTAPS, 9: total taps; odd, ≥3. NUNIQ = (NTAPS+1)/2 unique coefficients.
- DATA_W, 16: input/output sample width, signed.
- COEF_W, 16: coefficient width, signed.
- OUT_SHIFT, 0: arithmetic right shift applied before saturation, 0..COEF_W.
- ADD_MODE, 0: 0 = exact adders. 1 = team approximate 16-bit adder cell in the tree; legal only when DATA_W=16, COEF_W=16 and OUT_SHIFT=0; elaboration error otherwise.
- COEF_INIT, {2,0,6,18,-32}: reset coefficient values c[0..NUNIQ-1]; c[0] is the outermost tap, c[NUNIQ-1] the centre tap.

Ports:
- clk, in, 1: clock, rising edge.
- rstN, in, 1: synchronous active-low reset.
- flush, in, 1: synchronous clear of delay line and pipeline; coefficients kept.
- in_valid, in, 1: x is a valid sample this cycle.
- x, in, DATA_W: signed input sample.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, clog2(NUNIQ): coefficient index.
- coef_wdata, in, COEF_W: signed coefficient value.
- out_valid, out, 1: y valid; one-cycle pulse per accepted sample.
- y, out, DATA_W: signed filtered output.
- out_sat, out, 1: y was saturated this output; qualified by out_valid.
- sat_sticky, out, 1: set on any saturation; cleared only by rstN or flush.

Behaviour:
- Reset (rstN=0 at an edge):
  - delay line and all pipeline registers cleared.
  - coefficients loaded from COEF_INIT.
  - out_valid=0, y=0, out_sat=0, sat_sticky=0.
  - Reset mid-stream discards all in-flight samples; no out_valid pulse follows for any of them.
- Delay line d[0..NTAPS-1] shifts only on edges where in_valid=1: d[0]<=x, d[k]<=d[k-1]. Bubbles leave the line unchanged.
- S1 (edge t+1 after acceptance at edge t):
  - pre-add p[k] = d[k] + d[NTAPS-1-k] for k<NUNIQ-1, width DATA_W+1.
  - centre term p[NUNIQ-1] = d[NUNIQ-1].
  - prod[k] = p[k]*c[k], full precision, registered.
  - No implied negation of any tap; signs come from the coefficients.
- S2 (t+2):
  - sum of all prod[k] registered, ACC_W = DATA_W+COEF_W+1+clog2(NUNIQ), no overflow in exact mode.
  - ADD_MODE=1: products truncated to 16 bits, summed by a serial chain of approximate cells, 16-bit result, wrap-around.
- S3 (t+3):
  - if OUT_SHIFT>0, add 2^(OUT_SHIFT-1), then arithmetic shift right (round half up).
  - saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; drive y, out_sat, out_valid=1.
  - ADD_MODE=1 performs no rounding or saturation; out_sat=0.
- Latency: exactly 3 cycles from acceptance edge to out_valid. Throughput: one sample per cycle; no backpressure.
- When out_valid=0, y and out_sat hold their last values.
- Coefficient writes:
  - write takes effect at the edge where coef_we=1.
  - S1 products use the coefficient values present before that edge, so a write coincident with the edge computing S1 affects the next sample.
  - coef_addr ≥ NUNIQ is ignored.
  - Writes are accepted during flush.
- flush=1 at an edge:
  - clears delay line, pipeline valids, y, out_sat and sat_sticky.
  - in_valid in the same cycle is ignored.
  - Priority: rstN > flush > in_valid.

Decomposition:
- Package fir_sym_pkg holds:
  - width helper functions: ACC_W, clog2.
  - ADD_MODE enum {ADD_EXACT, ADD_APPROX}.
  - default COEF_INIT constant.
- One sub-module, fir_add_cell, selects the exact adder or the approximate 16-bit cell per ADD_MODE. The adder tree instantiates it.

Test Plan (defaults, ADD_MODE=0, unless noted):
- Impulse: x=1 then 0s, in_valid continuous → out_valid starts 3 cycles after acceptance; y = 2,0,6,18,-32,18,6,0,2, then 0.
- Step plus saturation:
  - x=100 held → steady y=2000 (coefficient sum 20).
  - x=32767 held → y=32767, out_sat=1, sat_sticky=1.
  - x=-32768 held → y=-32768.
- Bubbles: impulse with in_valid toggling 1,0,1,0 → same y sequence as the impulse test, out_valid only on accepted samples, spacing preserved.
- Rounding, OUT_SHIFT=2: impulse x=3 → y = 2,0,5,14,-24,14,5,0,2.
- Coefficient write: write c[4]=0 mid-stream → outputs for later samples drop the centre term; out-of-range addr 7 changes nothing.
- Reset/flush mid-stream:
  - rstN=0 one cycle → next cycle out_valid=0, y=0, coefficients back to COEF_INIT.
  - flush → no pulses for the 3 in-flight samples; sat_sticky=0.

Source files
------------

// File: rtl/fir_sym_pkg.sv
// fir_sym_pkg: shared constants and width helpers for the symmetric FIR.
//   add_mode_e    : adder selection for the product-sum tree.
//   clog2/acc_w   : elaboration-time width helpers.
//   COEF_INIT_DEF : reset coefficients c[0..4], outermost tap first.
package fir_sym_pkg;

  typedef enum logic [0:0] {
    ADD_EXACT  = 1'b0,
    ADD_APPROX = 1'b1
  } add_mode_e;

  // Approximate cell: fixed 16-bit width, low APPROX_LOW bits are OR-ed.
  localparam int APPROX_W   = 16;
  localparam int APPROX_LOW = 4;

  localparam int COEF_INIT_DEF [5] = '{2, 0, 6, 18, -32};

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-precision accumulator width: pre-add growth (+1) plus sum growth.
  function automatic int acc_w(input int data_w, input int coef_w, input int nuniq);
    return data_w + coef_w + 1 + clog2(nuniq);
  endfunction

endpackage

// File: rtl/fir_add_cell.sv
// fir_add_cell: one two-input adder of the product-sum chain.
//   MODE = ADD_EXACT  : plain W-bit wrap-around add.
//   MODE = ADD_APPROX : 16-bit lower-part-OR adder. The low APPROX_LOW bits
//                       are a|b; the upper part is an exact add whose
//                       carry-in is guessed from the top low-part bits.
// Ports: a_i, b_i (W-bit operands), s_o (W-bit sum).
module fir_add_cell
  import fir_sym_pkg::*;
#(
  parameter int W    = 16,
  parameter int MODE = 0
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o
);

  if (MODE == int'(ADD_APPROX)) begin : g_approx
    localparam int L = APPROX_LOW;
    logic carry;
    assign carry       = a_i[L-1] & b_i[L-1];
    assign s_o[L-1:0]  = a_i[L-1:0] | b_i[L-1:0];
    assign s_o[W-1:L]  = a_i[W-1:L] + b_i[W-1:L] + {{(W-L-1){1'b0}}, carry};
  end else begin : g_exact
    assign s_o = a_i + b_i;
  end

endmodule

// File: rtl/fir_sym_pipe.sv
// fir_sym_pipe: pipelined symmetric (linear-phase) FIR filter.
// Ports:
//   clk, rstN (sync, active low), flush (sync clear, keeps coefficients)
//   in_valid, x           : input sample stream
//   coef_we, coef_addr,
//   coef_wdata            : runtime coefficient write port
//   out_valid, y, out_sat : filtered output, saturation flag for this output
//   sat_sticky            : any saturation since last reset/flush
// Handshake: no backpressure. Every edge with in_valid=1 (and no reset or
// flush) accepts x; exactly three edges later out_valid pulses for one cycle
// with that sample's result. y/out_sat hold between pulses.
module fir_sym_pipe
  import fir_sym_pkg::*;
#(
  parameter int NTAPS     = 9,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 0,
  parameter int ADD_MODE  = 0,
  parameter int COEF_INIT [(NTAPS+1)/2] = COEF_INIT_DEF
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             x,
  input  logic                          coef_we,
  input  logic [clog2((NTAPS+1)/2)-1:0] coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             y,
  output logic                          out_sat,
  output logic                          sat_sticky
);

  localparam int NUNIQ   = (NTAPS + 1) / 2;
  localparam int AW      = clog2(NUNIQ);
  localparam int P_W     = DATA_W + 1;
  localparam int PROD_W  = P_W + COEF_W;
  localparam int ACC_W   = acc_w(DATA_W, COEF_W, NUNIQ);
  localparam bit APPROX  = (ADD_MODE == int'(ADD_APPROX));
  localparam int SUM_W   = APPROX ? APPROX_W : ACC_W;
  localparam int HALF_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND_HALF =
    (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << HALF_SH) : '0;
  localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  if (NTAPS < 3 || (NTAPS % 2) == 0) begin : g_bad_ntaps
    $error("fir_sym_pipe: NTAPS must be odd and >= 3");
  end
  if (OUT_SHIFT < 0 || OUT_SHIFT > COEF_W) begin : g_bad_shift
    $error("fir_sym_pipe: OUT_SHIFT out of range");
  end
  if (APPROX && !(DATA_W == 16 && COEF_W == 16 && OUT_SHIFT == 0)) begin : g_bad_approx
    $error("fir_sym_pipe: ADD_MODE=1 needs DATA_W=16, COEF_W=16, OUT_SHIFT=0");
  end

  logic signed [COEF_W-1:0] coef_q [NUNIQ];
  logic signed [DATA_W-1:0] d_q    [NTAPS];
  logic signed [P_W-1:0]    pre    [NUNIQ];
  logic signed [PROD_W-1:0] prod_d [NUNIQ];
  logic signed [PROD_W-1:0] prod_q [NUNIQ];
  logic        [SUM_W-1:0]  term   [NUNIQ];
  logic        [SUM_W-1:0]  sum_d  [NUNIQ];
  logic signed [SUM_W-1:0]  acc_q;
  logic signed [ACC_W:0]    rnd;
  logic        [DATA_W-1:0] y_d, y_q;
  logic                     sat_d, out_sat_q, sat_sticky_q;
  logic                     smp_v_q, s1_v_q, s2_v_q, out_v_q;

  // Coefficients: a write lands at its edge, so S1 at that same edge still
  // multiplies by the old value. Out-of-range addresses match no entry.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int k = 0; k < NUNIQ; k++) coef_q[k] <= COEF_W'(COEF_INIT[k]);
    end else if (coef_we) begin
      for (int k = 0; k < NUNIQ; k++)
        if (coef_addr == AW'(k)) coef_q[k] <= coef_wdata;
    end
  end

  // S1: fold symmetric taps, then one multiply per unique coefficient.
  always_comb begin
    for (int k = 0; k < NUNIQ - 1; k++)
      pre[k] = P_W'(d_q[k]) + P_W'(d_q[NTAPS-1-k]);
    pre[NUNIQ-1] = P_W'(d_q[NUNIQ-1]);
    for (int k = 0; k < NUNIQ; k++)
      prod_d[k] = PROD_W'(pre[k]) * PROD_W'(coef_q[k]);
  end

  // S2: serial chain of adder cells. Exact mode sign-extends the products to
  // SUM_W; approximate mode keeps only their low 16 bits.
  for (genvar k = 0; k < NUNIQ; k++) begin : g_term
    assign term[k] = SUM_W'(prod_q[k]);
  end
  assign sum_d[0] = term[0];
  for (genvar k = 1; k < NUNIQ; k++) begin : g_chain
    fir_add_cell #(.W(SUM_W), .MODE(ADD_MODE)) u_add (
      .a_i (sum_d[k-1]),
      .b_i (term[k]),
      .s_o (sum_d[k])
    );
  end

  // S3: round half up, arithmetic shift, saturate. One extra bit keeps the
  // rounding add from overflowing.
  always_comb begin
    rnd   = ((ACC_W+1)'(acc_q) + RND_HALF) >>> OUT_SHIFT;
    y_d   = rnd[DATA_W-1:0];
    sat_d = 1'b0;
    if (APPROX) begin
      y_d = DATA_W'(acc_q);
    end else if (rnd > Y_MAX) begin
      y_d   = Y_MAX[DATA_W-1:0];
      sat_d = 1'b1;
    end else if (rnd < Y_MIN) begin
      y_d   = Y_MIN[DATA_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN || flush) begin
      for (int k = 0; k < NTAPS; k++) d_q[k] <= '0;
      for (int k = 0; k < NUNIQ; k++) prod_q[k] <= '0;
      acc_q        <= '0;
      smp_v_q      <= 1'b0;
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      out_v_q      <= 1'b0;
      y_q          <= '0;
      out_sat_q    <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      if (in_valid) begin
        d_q[0] <= x;
        for (int k = 1; k < NTAPS; k++) d_q[k] <= d_q[k-1];
      end
      for (int k = 0; k < NUNIQ; k++) prod_q[k] <= prod_d[k];
      acc_q   <= sum_d[NUNIQ-1];
      smp_v_q <= in_valid;
      s1_v_q  <= smp_v_q;
      s2_v_q  <= s1_v_q;
      out_v_q <= s2_v_q;
      if (s2_v_q) begin
        y_q       <= y_d;
        out_sat_q <= sat_d;
        if (sat_d) sat_sticky_q <= 1'b1;
      end
    end
  end

  assign out_valid  = out_v_q;
  assign y          = y_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_fir_sym_pipe.sv
module tb_fir_sym_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] x;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        out_valid, out_sat, sat_sticky;
  logic [15:0] y;
  logic        out_valid2, out_sat2, sat_sticky2;
  logic [15:0] y2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_y_q[$];
  logic        obs_sat_q[$];
  int          obs_cyc_q[$];
  int          acc_cyc_q[$];
  logic [15:0] obs_y2_q[$];

  fir_sym_pipe dut (
    .clk(clk), .rstN(rst_n), .flush(flush), .in_valid(in_valid), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .y(y), .out_sat(out_sat), .sat_sticky(sat_sticky)
  );

  fir_sym_pipe #(.OUT_SHIFT(2)) dut_rnd (
    .clk(clk), .rstN(rst_n), .flush(flush), .in_valid(in_valid), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid2), .y(y2), .out_sat(out_sat2), .sat_sticky(sat_sticky2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output collector: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (out_valid) begin
      obs_y_q.push_back(y);
      obs_sat_q.push_back(out_sat);
      obs_cyc_q.push_back(cyc);
    end
    if (out_valid2) obs_y2_q.push_back(y2);
  end

  // driver tasks
  task automatic cycle(input logic v, input logic [15:0] xv, input logic we = 1'b0,
                       input logic [2:0] a = 3'd0, input logic [15:0] wd = 16'd0);
    in_valid = v; x = xv; coef_we = we; coef_addr = a; coef_wdata = wd;
    @(posedge clk); #2;
    if (v && rst_n && !flush) acc_cyc_q.push_back(cyc);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle(1'b0, 16'd0);
    flush = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_y_q.delete(); obs_sat_q.delete();
    obs_cyc_q.delete(); acc_cyc_q.delete(); obs_y2_q.delete();
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b1, 16'h1234);
    cycle(1'b1, 16'h4321);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_vec++; if (y !== 16'd0) begin n_err++; $display("FAIL reset_y got %0d exp 0", $signed(y)); end
    n_vec++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_out_sat got %b exp 0", out_sat); end
    n_vec++; if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sat_sticky got %b exp 0", sat_sticky); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_impulse();
    int imp [12] = '{2, 0, 6, 18, -32, 18, 6, 0, 2, 0, 0, 0};
    clear_q();
    foreach (imp[i]) exp_q.push_back(16'(imp[i]));
    cycle(1'b1, 16'd1);
    repeat (11) cycle(1'b1, 16'd0);
    idle(4);
    n_vec++;
    if (obs_y_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL impulse_count got %0d exp %0d", obs_y_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_y_q.size(); i++) begin
      n_vec++;
      if (obs_y_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL impulse_y[%0d] got %0d exp %0d", i, $signed(obs_y_q[i]), $signed(exp_q[i]));
      end
      n_vec++;
      if (obs_cyc_q[i] - acc_cyc_q[i] != 3) begin
        n_err++; $display("FAIL impulse_latency[%0d] got %0d exp 3", i, obs_cyc_q[i] - acc_cyc_q[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    int imp [12] = '{2, 0, 6, 18, -32, 18, 6, 0, 2, 0, 0, 0};
    do_flush();
    clear_q();
    foreach (imp[i]) exp_q.push_back(16'(imp[i]));
    cycle(1'b1, 16'd1);
    repeat (11) begin
      cycle(1'b0, 16'h7fff);
      cycle(1'b1, 16'd0);
    end
    idle(4);
    n_vec++;
    if (obs_y_q.size() != 12) begin
      n_err++; $display("FAIL bubbles_count got %0d exp 12", obs_y_q.size());
    end
    for (int i = 0; i < 12 && i < obs_y_q.size(); i++) begin
      n_vec++;
      if (obs_y_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bubbles_y[%0d] got %0d exp %0d", i, $signed(obs_y_q[i]), $signed(exp_q[i]));
      end
      n_vec++;
      if (obs_cyc_q[i] - acc_cyc_q[i] != 3) begin
        n_err++; $display("FAIL bubbles_latency[%0d] got %0d exp 3", i, obs_cyc_q[i] - acc_cyc_q[i]);
      end
    end
  endtask

  task automatic test_step_sat();
    do_flush();
    clear_q();
    repeat (12) cycle(1'b1, 16'd100);
    idle(4);
    n_vec++; if (obs_y_q.size() != 12) begin n_err++; $display("FAIL step_count got %0d exp 12", obs_y_q.size()); end
    n_vec++; if (y !== 16'd2000) begin n_err++; $display("FAIL step_y got %0d exp 2000", $signed(y)); end
    n_vec++; if (out_sat !== 1'b0 || sat_sticky !== 1'b0) begin
      n_err++; $display("FAIL step_sat got %b/%b exp 0/0", out_sat, sat_sticky);
    end
    repeat (12) cycle(1'b1, 16'd32767);
    idle(4);
    n_vec++; if (y !== 16'd32767) begin n_err++; $display("FAIL satpos_y got %0d exp 32767", $signed(y)); end
    n_vec++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL satpos_out_sat got %b exp 1", out_sat); end
    n_vec++; if (sat_sticky !== 1'b1) begin n_err++; $display("FAIL satpos_sticky got %b exp 1", sat_sticky); end
    repeat (12) cycle(1'b1, 16'h8000);
    idle(4);
    n_vec++; if (y !== 16'h8000) begin n_err++; $display("FAIL satneg_y got %0d exp -32768", $signed(y)); end
    n_vec++; if (out_sat !== 1'b1) begin n_err++; $display("FAIL satneg_out_sat got %b exp 1", out_sat); end
    idle(3);
    n_vec++; if (out_valid !== 1'b0 || y !== 16'h8000) begin
      n_err++; $display("FAIL hold_y got %0d (valid %b) exp -32768 (valid 0)", $signed(y), out_valid);
    end
  endtask

  task automatic test_rounding();
    int r [9] = '{2, 0, 5, 14, -24, 14, 5, 0, 2};
    do_flush();
    clear_q();
    cycle(1'b1, 16'd3);
    repeat (8) cycle(1'b1, 16'd0);
    idle(4);
    n_vec++;
    if (obs_y2_q.size() != 9) begin n_err++; $display("FAIL round_count got %0d exp 9", obs_y2_q.size()); end
    for (int i = 0; i < 9 && i < obs_y2_q.size(); i++) begin
      n_vec++;
      if (obs_y2_q[i] !== 16'(r[i])) begin
        n_err++; $display("FAIL round_y[%0d] got %0d exp %0d", i, $signed(obs_y2_q[i]), r[i]);
      end
    end
  endtask

  task automatic test_coef_write();
    int imp [9] = '{2, 0, 6, 18, -32, 18, 6, 0, 2};
    do_flush();
    clear_q();
    cycle(1'b0, 16'd0, 1'b1, 3'd7, 16'd100);  // out of range: ignored
    cycle(1'b1, 16'd1);
    repeat (8) cycle(1'b1, 16'd0);
    idle(4);
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (i >= obs_y_q.size() || obs_y_q[i] !== 16'(imp[i])) begin
        n_err++; $display("FAIL coef_oob_y[%0d] got %0d exp %0d", i,
                          (i < obs_y_q.size()) ? $signed(obs_y_q[i]) : 16'sd0, imp[i]);
      end
    end
    do_flush();
    clear_q();
    repeat (12) cycle(1'b1, 16'd100);
    cycle(1'b1, 16'd100, 1'b1, 3'd4, 16'd0);  // c[4]=0 on this sample's accept edge
    repeat (11) cycle(1'b1, 16'd100);
    idle(4);
    n_vec++; if (obs_y_q.size() != 24) begin n_err++; $display("FAIL coef_count got %0d exp 24", obs_y_q.size()); end
    if (obs_y_q.size() == 24) begin
      n_vec++; if (obs_y_q[11] !== 16'd2000) begin n_err++; $display("FAIL coef_before got %0d exp 2000", $signed(obs_y_q[11])); end
      n_vec++; if (obs_y_q[12] !== 16'd5200) begin n_err++; $display("FAIL coef_first_new got %0d exp 5200", $signed(obs_y_q[12])); end
      n_vec++; if (obs_y_q[23] !== 16'd5200) begin n_err++; $display("FAIL coef_last got %0d exp 5200", $signed(obs_y_q[23])); end
    end
    cycle(1'b0, 16'd0, 1'b1, 3'd4, 16'hffe0);  // restore c[4] = -32
  endtask

  task automatic test_reset_mid();
    int imp [9] = '{2, 0, 6, 18, -32, 18, 6, 0, 2};
    cycle(1'b0, 16'd0, 1'b1, 3'd0, 16'd5);  // c[0]=5, reset must undo it
    clear_q();
    cycle(1'b1, 16'd1);
    cycle(1'b1, 16'd9);
    rst_n = 1'b0;
    cycle(1'b1, 16'd7);
    rst_n = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || y !== 16'd0) begin
      n_err++; $display("FAIL rstmid_out got valid %b y %0d exp valid 0 y 0", out_valid, $signed(y));
    end
    idle(5);
    n_vec++; if (obs_y_q.size() != 0) begin n_err++; $display("FAIL rstmid_pulses got %0d exp 0", obs_y_q.size()); end
    clear_q();
    cycle(1'b1, 16'd1);
    repeat (8) cycle(1'b1, 16'd0);
    idle(4);
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (i >= obs_y_q.size() || obs_y_q[i] !== 16'(imp[i])) begin
        n_err++; $display("FAIL rstmid_coef_y[%0d] got %0d exp %0d", i,
                          (i < obs_y_q.size()) ? $signed(obs_y_q[i]) : 16'sd0, imp[i]);
      end
    end
  endtask

  task automatic test_flush_mid();
    do_flush();
    repeat (12) cycle(1'b1, 16'd32767);
    clear_q();
    flush = 1'b1;
    cycle(1'b1, 16'd1);  // sample offered during flush must be dropped
    flush = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || y !== 16'd0 || out_sat !== 1'b0) begin
      n_err++; $display("FAIL flush_out got valid %b y %0d sat %b exp 0 0 0", out_valid, $signed(y), out_sat);
    end
    n_vec++; if (sat_sticky !== 1'b0) begin n_err++; $display("FAIL flush_sticky got %b exp 0", sat_sticky); end
    idle(4);
    n_vec++; if (obs_y_q.size() != 0) begin n_err++; $display("FAIL flush_pulses got %0d exp 0", obs_y_q.size()); end
    repeat (10) cycle(1'b1, 16'd0);
    idle(4);
    n_vec++; if (obs_y_q.size() != 10) begin n_err++; $display("FAIL flush_after_count got %0d exp 10", obs_y_q.size()); end
    for (int i = 0; i < obs_y_q.size(); i++) begin
      n_vec++;
      if (obs_y_q[i] !== 16'd0) begin
        n_err++; $display("FAIL flush_after_y[%0d] got %0d exp 0", i, $signed(obs_y_q[i]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; x = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    test_reset();
    test_impulse();
    test_bubbles();
    test_step_sat();
    test_rounding();
    test_coef_write();
    test_reset_mid();
    test_flush_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
